// File: rtl/irq_reset_sequencer.sv
// ---------------------------------------------------------------------------
// irq_reset_sequencer
//   Interrupt/reset front end of the 6502 control path. Synchronises the
//   RDY-qualified IRQ/NMI/SO pins, detects NMI and SO falling edges,
//   arbitrates RESET > NMI > BRK > IRQ and runs the interrupt-entry sequence
//   (dummy, three stack cycles, two vector reads), driving the decoder and
//   register-file strobes.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   rdy               RDY pin, high = run
//   nmi, irq, so      active-low pins (NMI/SO falling edge, IRQ level)
//   sync, brk_op      decoder: instruction boundary / BRK opcode in T1
//   i_flag            current P.I
//   int_pending       NMI latch or unmasked IRQ present
//   seq_busy          entry sequence in progress
//   int_kind          00 none, 01 IRQ/BRK, 10 NMI, 11 RESET
//   force_brk         substitute 00 into IR in this sync cycle
//   push_pch/pcl/p    stack cycle strobes, wr_en = stack cycle is a write
//   b_flag            B bit for the pushed P
//   vec_fetch_lo/hi   vector byte reads, vector_addr = address of the read
//   set_i, set_v      set P.I / P.V
// ---------------------------------------------------------------------------
module irq_reset_sequencer #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] NMI_VEC     = 16'hFFFA,
  parameter logic [15:0] RST_VEC     = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC     = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        nmi,
  input  logic        irq,
  input  logic        so,
  input  logic        sync,
  input  logic        brk_op,
  input  logic        i_flag,
  output logic        int_pending,
  output logic        seq_busy,
  output logic [1:0]  int_kind,
  output logic        force_brk,
  output logic        push_pch,
  output logic        push_pcl,
  output logic        push_p,
  output logic        wr_en,
  output logic        b_flag,
  output logic        vec_fetch_lo,
  output logic        vec_fetch_hi,
  output logic [15:0] vector_addr,
  output logic        set_i,
  output logic        set_v
);

  typedef enum logic [2:0] {
    ST_RST_WAIT = 3'd0,
    ST_IDLE     = 3'd1,
    ST_DUMMY    = 3'd2,
    ST_PUSH_H   = 3'd3,
    ST_PUSH_L   = 3'd4,
    ST_PUSH_P   = 3'd5,
    ST_VEC_L    = 3'd6,
    ST_VEC_H    = 3'd7
  } state_t;

  localparam logic [1:0] KIND_IRQ = 2'b01;
  localparam logic [1:0] KIND_NMI = 2'b10;
  localparam logic [1:0] KIND_RST = 2'b11;

  state_t                 state_r;
  state_t                 state_s;
  logic [SYNC_STAGES-1:0] nmi_sync_r;
  logic [SYNC_STAGES-1:0] irq_sync_r;
  logic [SYNC_STAGES-1:0] so_sync_r;
  logic                   nmi_prev_r;
  logic                   so_prev_r;
  logic                   nmi_latch_r;
  logic                   skip_r;
  logic [1:0]             kind_r;
  logic                   b_flag_r;
  logic [15:0]            vec_r;
  logic                   set_v_r;

  logic nmi_lvl_s;
  logic irq_lvl_s;
  logic so_lvl_s;
  logic nmi_edge_s;
  logic so_edge_s;
  logic irq_req_s;
  logic pending_s;
  logic kind_is_rst_s;
  logic stall_s;
  logic accept_brk_s;
  logic accept_int_s;
  logic vec_sel_s;
  logic nmi_take_s;

  assign nmi_lvl_s     = nmi_sync_r[SYNC_STAGES-1];
  assign irq_lvl_s     = irq_sync_r[SYNC_STAGES-1];
  assign so_lvl_s      = so_sync_r[SYNC_STAGES-1];
  assign nmi_edge_s    = nmi_prev_r & ~nmi_lvl_s;
  assign so_edge_s     = so_prev_r & ~so_lvl_s;
  assign irq_req_s     = ~irq_lvl_s & ~i_flag;
  assign pending_s     = nmi_latch_r | irq_req_s;
  assign kind_is_rst_s = (kind_r == KIND_RST);
  // BRK wins over an interrupt request presented in the same cycle.
  assign accept_brk_s  = (state_r == ST_IDLE) & rdy & brk_op;
  assign accept_int_s  = (state_r == ST_IDLE) & rdy & sync & pending_s & ~skip_r & ~brk_op;
  // Vector is chosen exactly once, on the PUSH_P -> VEC_L transition.
  assign vec_sel_s     = (state_r == ST_PUSH_P) & ~stall_s;
  assign nmi_take_s    = vec_sel_s & ~kind_is_rst_s & nmi_latch_r;

  // Pin synchronisers (preset inactive) and edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_sync_r <= '1;
      irq_sync_r <= '1;
      so_sync_r  <= '1;
      nmi_prev_r <= 1'b1;
      so_prev_r  <= 1'b1;
    end else begin
      nmi_sync_r[0] <= nmi;
      irq_sync_r[0] <= irq;
      so_sync_r[0]  <= so;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        nmi_sync_r[i] <= nmi_sync_r[i-1];
        irq_sync_r[i] <= irq_sync_r[i-1];
        so_sync_r[i]  <= so_sync_r[i-1];
      end
      nmi_prev_r <= nmi_lvl_s;
      so_prev_r  <= so_lvl_s;
    end
  end

  // RDY stall: reads always stall, stack cycles only when they are reads (reset).
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      ST_DUMMY, ST_VEC_L, ST_VEC_H:    stall_s = ~rdy;
      ST_PUSH_H, ST_PUSH_L, ST_PUSH_P: stall_s = ~rdy & kind_is_rst_s;
      default:                         stall_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RST_WAIT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_RST_WAIT: state_s = ST_DUMMY;
      ST_IDLE: begin
        if (accept_brk_s) begin
          state_s = ST_PUSH_H;
        end else if (accept_int_s) begin
          state_s = ST_DUMMY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DUMMY:  state_s = stall_s ? ST_DUMMY  : ST_PUSH_H;
      ST_PUSH_H: state_s = stall_s ? ST_PUSH_H : ST_PUSH_L;
      ST_PUSH_L: state_s = stall_s ? ST_PUSH_L : ST_PUSH_P;
      ST_PUSH_P: state_s = stall_s ? ST_PUSH_P : ST_VEC_L;
      ST_VEC_L:  state_s = stall_s ? ST_VEC_L  : ST_VEC_H;
      ST_VEC_H:  state_s = stall_s ? ST_VEC_H  : ST_IDLE;
      default:   state_s = ST_RST_WAIT;
    endcase
  end

  // Sequence context: kind, B value, vector, NMI latch, skip, SO pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      kind_r      <= 2'b00;
      b_flag_r    <= 1'b0;
      vec_r       <= 16'h0000;
      nmi_latch_r <= 1'b0;
      skip_r      <= 1'b0;
      set_v_r     <= 1'b0;
    end else begin
      set_v_r <= so_edge_s;

      if (state_r == ST_RST_WAIT) begin
        kind_r   <= KIND_RST;
        b_flag_r <= 1'b0;
      end else if (accept_brk_s) begin
        kind_r   <= KIND_IRQ;
        b_flag_r <= 1'b1;
      end else if (accept_int_s) begin
        kind_r   <= nmi_latch_r ? KIND_NMI : KIND_IRQ;
        b_flag_r <= 1'b0;
      end else if (nmi_take_s) begin
        // NMI hijacks an IRQ/BRK sequence; the pushed B value is kept.
        kind_r   <= KIND_NMI;
        b_flag_r <= b_flag_r;
      end else begin
        kind_r   <= kind_r;
        b_flag_r <= b_flag_r;
      end

      if (vec_sel_s) begin
        if (kind_is_rst_s) begin
          vec_r <= RST_VEC;
        end else if (nmi_latch_r) begin
          vec_r <= NMI_VEC;
        end else begin
          vec_r <= IRQ_VEC;
        end
      end else begin
        vec_r <= vec_r;
      end

      // Clearing wins: an edge arriving while the latch is set is absorbed.
      if (nmi_take_s) begin
        nmi_latch_r <= 1'b0;
      end else begin
        nmi_latch_r <= nmi_latch_r | nmi_edge_s;
      end

      if ((state_r == ST_VEC_H) && !stall_s) begin
        skip_r <= 1'b1;
      end else if ((state_r == ST_IDLE) && sync && rdy) begin
        skip_r <= 1'b0;
      end else begin
        skip_r <= skip_r;
      end
    end
  end

  // Output decode from state and sequence context.
  always_comb begin
    seq_busy     = 1'b0;
    push_pch     = 1'b0;
    push_pcl     = 1'b0;
    push_p       = 1'b0;
    wr_en        = 1'b0;
    vec_fetch_lo = 1'b0;
    vec_fetch_hi = 1'b0;
    vector_addr  = 16'h0000;
    set_i        = 1'b0;
    case (state_r)
      ST_DUMMY: seq_busy = 1'b1;
      ST_PUSH_H: begin
        seq_busy = 1'b1;
        push_pch = 1'b1;
        wr_en    = ~kind_is_rst_s;
      end
      ST_PUSH_L: begin
        seq_busy = 1'b1;
        push_pcl = 1'b1;
        wr_en    = ~kind_is_rst_s;
      end
      ST_PUSH_P: begin
        seq_busy = 1'b1;
        push_p   = 1'b1;
        wr_en    = ~kind_is_rst_s;
      end
      ST_VEC_L: begin
        seq_busy     = 1'b1;
        vec_fetch_lo = 1'b1;
        vector_addr  = vec_r;
      end
      ST_VEC_H: begin
        seq_busy     = 1'b1;
        vec_fetch_hi = 1'b1;
        vector_addr  = vec_r + 16'd1;
        set_i        = 1'b1;
      end
      default: seq_busy = 1'b0;
    endcase

    if (seq_busy) begin
      int_kind = kind_r;
      b_flag   = b_flag_r;
    end else begin
      int_kind = 2'b00;
      b_flag   = 1'b0;
    end

    force_brk   = accept_int_s;
    int_pending = pending_s;
    set_v       = set_v_r;
  end

endmodule
